// File: rtl/bs_comp_serial_driver.sv
// +-----------------------------------------------------------------------------+
// | bs_comp_serial_driver : MSB-first serial driver/resolver for a 1-bit         |
// | comparator slice. Optional macro BS_COMP_EARLY_EXIT_EN.   Revision: 1.0      |
// +-----------------------------------------------------------------------------+
`default_nettype none

module bs_comp_serial_driver #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             a_bit,
  output logic             b_bit,
  input  logic             bit_lt,
  input  logic             bit_eq,
  input  logic             bit_gt,
  output logic             busy,
  output logic             done,
  output logic             LT,
  output logic             EQ,
  output logic             GT,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             decided_q, decided_d;
  logic             gt_dir_q, gt_dir_d;
  logic             err_int_q, err_int_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             err_q, err_d;

  logic             slice_ok;
  logic             new_dec;
  logic             dec_now;
  logic             gt_now;
  logic             err_now;
  logic             commit;

  always_comb begin
    slice_ok = (bit_lt & ~bit_eq & ~bit_gt) |
               (~bit_lt & bit_eq & ~bit_gt) |
               (~bit_lt & ~bit_eq & bit_gt);
    // The first valid difference wins; later bits are less significant.
    new_dec  = ~decided_q & slice_ok & (bit_lt | bit_gt);
    dec_now  = decided_q | new_dec;
    gt_now   = new_dec ? bit_gt : gt_dir_q;
    err_now  = err_int_q | ~slice_ok;
`ifdef BS_COMP_EARLY_EXIT_EN
    commit   = (cnt_q == '0) | new_dec | ~slice_ok;
`else
    commit   = (cnt_q == '0);
`endif

    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    gt_dir_d  = gt_dir_q;
    err_int_d = err_int_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    lt_d      = lt_q;
    eq_d      = eq_q;
    gt_d      = gt_q;
    err_d     = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d    = a_in;
          b_sh_d    = b_in;
          cnt_d     = CW'(WIDTH - 1);
          decided_d = 1'b0;
          gt_dir_d  = 1'b0;
          err_int_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        decided_d = dec_now;
        gt_dir_d  = gt_now;
        err_int_d = err_now;
        a_sh_d    = {a_sh_q[WIDTH-2:0], 1'b0};
        b_sh_d    = {b_sh_q[WIDTH-2:0], 1'b0};
        cnt_d     = cnt_q - CW'(1);
        if (commit) begin
          // Zeroed registers keep a_bit/b_bit low outside SHIFT.
          a_sh_d  = '0;
          b_sh_d  = '0;
          lt_d    = ~err_now & dec_now & ~gt_now;
          gt_d    = ~err_now & dec_now & gt_now;
          eq_d    = ~err_now & ~dec_now;
          err_d   = err_now;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      gt_dir_q  <= 1'b0;
      err_int_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      lt_q      <= 1'b0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      gt_dir_q  <= gt_dir_d;
      err_int_q <= err_int_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      lt_q      <= lt_d;
      eq_q      <= eq_d;
      gt_q      <= gt_d;
      err_q     <= err_d;
    end
  end

  assign a_bit = a_sh_q[WIDTH-1];
  assign b_bit = b_sh_q[WIDTH-1];
  assign busy  = busy_q;
  assign done  = done_q;
  assign LT    = lt_q;
  assign EQ    = eq_q;
  assign GT    = gt_q;
  assign err   = err_q;

endmodule

`default_nettype wire
